// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Purpose:
//   Owns the single SDRAM command/address bus. The init sequencer's bus is
//   passed straight through until INIT_DONE. After that, the bus goes to one
//   requester at a time: refresh first, then write, then read. Whoever owns
//   the bus keeps it until it pulses its *_END. After every transaction there
//   is at least one ARBIT cycle, during which a NOP is driven.
//
// Optional feature (macro SDRAM_ARB_RR_EN):
//   When the macro is defined, write and read alternate whenever both are
//   requesting. Refresh keeps absolute priority. When the macro is undefined,
//   write always wins over read.
//
// Ports:
//   Sys_clk, Rst_n                     clock, asynchronous active-low reset
//   INIT_DONE/CMD/ADDR/BA              init sequencer pulse and bus
//   AREF_REQ/END/CMD/ADDR/BA           refresh generator request, end, bus
//   WR_REQ/END/CMD/ADDR/BA             write controller request, end, bus
//   RD_REQ/END/CMD/ADDR/BA             read controller request, end, bus
//   AREF_EN, WR_EN, RD_EN              registered grants (at most one high)
//   SDRAM_CKE                          clock enable, 1 after the first edge
//                                      following reset release
//   SDRAM_CMD/ADDR/BA                  muxed SDRAM command bus
//   INIT_OK                            sticky init-complete flag
// -----------------------------------------------------------------------------
module sdram_arbiter #(
    parameter logic [3:0] CMD_NOP = 4'b0111,
    parameter int         ADDR_W  = 12,
    parameter int         BA_W    = 2
) (
    input  logic              Sys_clk,
    input  logic              Rst_n,
    input  logic              INIT_DONE,
    input  logic [3:0]        INIT_CMD,
    input  logic [ADDR_W-1:0] INIT_ADDR,
    input  logic [BA_W-1:0]   INIT_BA,
    input  logic              AREF_REQ,
    input  logic              AREF_END,
    input  logic [3:0]        AREF_CMD,
    input  logic [ADDR_W-1:0] AREF_ADDR,
    input  logic [BA_W-1:0]   AREF_BA,
    input  logic              WR_REQ,
    input  logic              WR_END,
    input  logic [3:0]        WR_CMD,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [BA_W-1:0]   WR_BA,
    input  logic              RD_REQ,
    input  logic              RD_END,
    input  logic [3:0]        RD_CMD,
    input  logic [ADDR_W-1:0] RD_ADDR,
    input  logic [BA_W-1:0]   RD_BA,
    output logic              AREF_EN,
    output logic              WR_EN,
    output logic              RD_EN,
    output logic              SDRAM_CKE,
    output logic [3:0]        SDRAM_CMD,
    output logic [ADDR_W-1:0] SDRAM_ADDR,
    output logic [BA_W-1:0]   SDRAM_BA,
    output logic              INIT_OK
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARBIT = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t r_state;
    logic   w_pick_wr;
    logic   w_pick_rd;

`ifdef SDRAM_ARB_RR_EN
    // Remembers which of write/read was granted most recently (1 = read).
    // It resets to "read" so that the first contested grant goes to write.
    logic r_last_rd;

    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_last_rd <= 1'b1;
        end else if (r_state == S_ARBIT && !AREF_REQ) begin
            if (w_pick_wr)
                r_last_rd <= 1'b0;
            else if (w_pick_rd)
                r_last_rd <= 1'b1;
        end
    end

    // When both are requesting, the side that was not served last wins.
    assign w_pick_wr = WR_REQ && (!RD_REQ || r_last_rd);
`else
    assign w_pick_wr = WR_REQ;
`endif
    assign w_pick_rd = RD_REQ && !w_pick_wr;

    // Arbitration FSM. Grants are registered in the same edge that enters
    // the owner state, so *_EN is high during the first owned cycle.
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= S_INIT;
            AREF_EN   <= 1'b0;
            WR_EN     <= 1'b0;
            RD_EN     <= 1'b0;
            INIT_OK   <= 1'b0;
            SDRAM_CKE <= 1'b0;
        end else begin
            SDRAM_CKE <= 1'b1;
            case (r_state)
                S_INIT: begin
                    if (INIT_DONE) begin
                        r_state <= S_ARBIT;
                        INIT_OK <= 1'b1;
                    end
                end
                S_ARBIT: begin
                    if (AREF_REQ) begin
                        r_state <= S_AREF;
                        AREF_EN <= 1'b1;
                    end else if (w_pick_wr) begin
                        r_state <= S_WRITE;
                        WR_EN   <= 1'b1;
                    end else if (w_pick_rd) begin
                        r_state <= S_READ;
                        RD_EN   <= 1'b1;
                    end
                end
                S_AREF: begin
                    if (AREF_END) begin
                        r_state <= S_ARBIT;
                        AREF_EN <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (WR_END) begin
                        r_state <= S_ARBIT;
                        WR_EN   <= 1'b0;
                    end
                end
                S_READ: begin
                    if (RD_END) begin
                        r_state <= S_ARBIT;
                        RD_EN   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    AREF_EN <= 1'b0;
                    WR_EN   <= 1'b0;
                    RD_EN   <= 1'b0;
                end
            endcase
        end
    end

    // The bus mux is purely combinational on the state, so an owner's
    // command reaches the pins in the same cycle it is driven.
    always_comb begin
        SDRAM_CMD  = CMD_NOP;
        SDRAM_ADDR = '0;
        SDRAM_BA   = '0;
        case (r_state)
            S_INIT: begin
                SDRAM_CMD  = INIT_CMD;
                SDRAM_ADDR = INIT_ADDR;
                SDRAM_BA   = INIT_BA;
            end
            S_AREF: begin
                SDRAM_CMD  = AREF_CMD;
                SDRAM_ADDR = AREF_ADDR;
                SDRAM_BA   = AREF_BA;
            end
            S_WRITE: begin
                SDRAM_CMD  = WR_CMD;
                SDRAM_ADDR = WR_ADDR;
                SDRAM_BA   = WR_BA;
            end
            S_READ: begin
                SDRAM_CMD  = RD_CMD;
                SDRAM_ADDR = RD_ADDR;
                SDRAM_BA   = RD_BA;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Self-checking bench for sdram_arbiter. Each stimulus step pushes the
// outputs expected after the next clock edge (or right away, for the reset
// checks) onto a scoreboard queue. These entries are popped and compared
// against the DUT 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam int O_INIT = 0;
    localparam int O_NOP  = 1;
    localparam int O_AREF = 2;
    localparam int O_WR   = 3;
    localparam int O_RD   = 4;

    localparam logic [3:0]  C_INIT = 4'b0010;
    localparam logic [11:0] A_INIT = 12'h400;
    localparam logic [1:0]  B_INIT = 2'd0;
    localparam logic [3:0]  C_AREF = 4'b0001;
    localparam logic [11:0] A_AREF = 12'h111;
    localparam logic [1:0]  B_AREF = 2'd1;
    localparam logic [3:0]  C_WR   = 4'b0100;
    localparam logic [11:0] A_WR   = 12'h0A5;
    localparam logic [1:0]  B_WR   = 2'd2;
    localparam logic [3:0]  C_RD   = 4'b0101;
    localparam logic [11:0] A_RD   = 12'h35A;
    localparam logic [1:0]  B_RD   = 2'd3;

    logic        Sys_clk = 1'b0;
    logic        Rst_n;
    logic        INIT_DONE;
    logic [3:0]  INIT_CMD;
    logic [11:0] INIT_ADDR;
    logic [1:0]  INIT_BA;
    logic        AREF_REQ, AREF_END;
    logic [3:0]  AREF_CMD;
    logic [11:0] AREF_ADDR;
    logic [1:0]  AREF_BA;
    logic        WR_REQ, WR_END;
    logic [3:0]  WR_CMD;
    logic [11:0] WR_ADDR;
    logic [1:0]  WR_BA;
    logic        RD_REQ, RD_END;
    logic [3:0]  RD_CMD;
    logic [11:0] RD_ADDR;
    logic [1:0]  RD_BA;
    logic        AREF_EN, WR_EN, RD_EN;
    logic        SDRAM_CKE;
    logic [3:0]  SDRAM_CMD;
    logic [11:0] SDRAM_ADDR;
    logic [1:0]  SDRAM_BA;
    logic        INIT_OK;

    sdram_arbiter u_dut (
        .Sys_clk    (Sys_clk),
        .Rst_n      (Rst_n),
        .INIT_DONE  (INIT_DONE),
        .INIT_CMD   (INIT_CMD),
        .INIT_ADDR  (INIT_ADDR),
        .INIT_BA    (INIT_BA),
        .AREF_REQ   (AREF_REQ),
        .AREF_END   (AREF_END),
        .AREF_CMD   (AREF_CMD),
        .AREF_ADDR  (AREF_ADDR),
        .AREF_BA    (AREF_BA),
        .WR_REQ     (WR_REQ),
        .WR_END     (WR_END),
        .WR_CMD     (WR_CMD),
        .WR_ADDR    (WR_ADDR),
        .WR_BA      (WR_BA),
        .RD_REQ     (RD_REQ),
        .RD_END     (RD_END),
        .RD_CMD     (RD_CMD),
        .RD_ADDR    (RD_ADDR),
        .RD_BA      (RD_BA),
        .AREF_EN    (AREF_EN),
        .WR_EN      (WR_EN),
        .RD_EN      (RD_EN),
        .SDRAM_CKE  (SDRAM_CKE),
        .SDRAM_CMD  (SDRAM_CMD),
        .SDRAM_ADDR (SDRAM_ADDR),
        .SDRAM_BA   (SDRAM_BA),
        .INIT_OK    (INIT_OK)
    );

    always #5 Sys_clk = ~Sys_clk;

    typedef struct packed {
        logic        aref;
        logic        wr;
        logic        rd;
        logic        ok;
        logic        cke;
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  ba;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int own, input logic ok, input logic cke);
        exp_t e;
        e = '0;
        e.ok  = ok;
        e.cke = cke;
        case (own)
            O_INIT: begin e.cmd = C_INIT; e.addr = A_INIT; e.ba = B_INIT; end
            O_AREF: begin e.aref = 1'b1; e.cmd = C_AREF; e.addr = A_AREF; e.ba = B_AREF; end
            O_WR:   begin e.wr = 1'b1; e.cmd = C_WR; e.addr = A_WR; e.ba = B_WR; end
            O_RD:   begin e.rd = 1'b1; e.cmd = C_RD; e.addr = A_RD; e.ba = B_RD; end
            default: begin e.cmd = 4'b0111; e.addr = '0; e.ba = '0; end
        endcase
        return e;
    endfunction

    task automatic compare_out();
        exp_t  e;
        string t;
        chk("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".aref_en"}, 32'(AREF_EN),    32'(e.aref));
            chk({t, ".wr_en"},   32'(WR_EN),      32'(e.wr));
            chk({t, ".rd_en"},   32'(RD_EN),      32'(e.rd));
            chk({t, ".init_ok"}, 32'(INIT_OK),    32'(e.ok));
            chk({t, ".cke"},     32'(SDRAM_CKE),  32'(e.cke));
            chk({t, ".cmd"},     32'(SDRAM_CMD),  32'(e.cmd));
            chk({t, ".addr"},    32'(SDRAM_ADDR), 32'(e.addr));
            chk({t, ".ba"},      32'(SDRAM_BA),   32'(e.ba));
            $display("[TB] %-14s cmd=%b addr=%h ba=%0d en(a/w/r)=%b%b%b ok=%b cke=%b",
                     t, SDRAM_CMD, SDRAM_ADDR, SDRAM_BA, AREF_EN, WR_EN, RD_EN,
                     INIT_OK, SDRAM_CKE);
        end
    endtask

    // One clock: push the expectation for after the edge, then compare.
    task automatic cyc(input string tag, input int own, input logic ok);
        exp_q.push_back(mk(own, ok, 1'b1));
        tag_q.push_back(tag);
        @(posedge Sys_clk);
        #1;
        compare_out();
    endtask

    // Immediate check with no clock edge (used for asynchronous reset).
    task automatic now_chk(input string tag, input int own, input logic ok, input logic cke);
        exp_q.push_back(mk(own, ok, cke));
        tag_q.push_back(tag);
        #1;
        compare_out();
    endtask

    initial begin
        automatic logic exp_last_wr = 1'b1;
        automatic logic aref_pend   = 1'b0;
        automatic int   own;

        Rst_n     = 1'b0;
        INIT_DONE = 1'b0;
        INIT_CMD  = C_INIT; INIT_ADDR = A_INIT; INIT_BA = B_INIT;
        AREF_REQ  = 1'b0; AREF_END = 1'b0;
        AREF_CMD  = C_AREF; AREF_ADDR = A_AREF; AREF_BA = B_AREF;
        WR_REQ    = 1'b0; WR_END = 1'b0;
        WR_CMD    = C_WR; WR_ADDR = A_WR; WR_BA = B_WR;
        RD_REQ    = 1'b0; RD_END = 1'b0;
        RD_CMD    = C_RD; RD_ADDR = A_RD; RD_BA = B_RD;

        #12;
        now_chk("reset", O_INIT, 1'b0, 1'b0);

        // Requests raised during INIT are ignored, but the ones still held
        // at exit get served.
        @(posedge Sys_clk); #1;
        Rst_n  = 1'b1;
        WR_REQ = 1'b1;
        RD_REQ = 1'b1;
        for (int i = 0; i < 3; i++) cyc("init", O_INIT, 1'b0);

        INIT_DONE = 1'b1;
        now_chk("init_pulse", O_INIT, 1'b0, 1'b1);
        cyc("init_exit", O_NOP, 1'b1);
        INIT_DONE = 1'b0;
        cyc("wr_after_init", O_WR, 1'b1);

        // END pulses from non-owners, and a dropped REQ, must not release the bus.
        RD_END = 1'b1; AREF_END = 1'b1; WR_REQ = 1'b0;
        cyc("wr_hold", O_WR, 1'b1);
        RD_END = 1'b0; AREF_END = 1'b0;
        cyc("wr_hold2", O_WR, 1'b1);
        WR_END = 1'b1;
        cyc("wr_release", O_NOP, 1'b1);
        WR_END = 1'b0;
        cyc("rd_grant", O_RD, 1'b1);
        RD_REQ = 1'b0; RD_END = 1'b1;
        cyc("rd_release", O_NOP, 1'b1);
        RD_END = 1'b0; WR_END = 1'b1;
        cyc("end_in_arbit", O_NOP, 1'b1);
        WR_END = 1'b0;

        // All three requests at once: refresh first, then write, then read.
        AREF_REQ = 1'b1; WR_REQ = 1'b1; RD_REQ = 1'b1;
        cyc("prio_aref", O_AREF, 1'b1);
        AREF_REQ = 1'b0;
        cyc("aref_hold", O_AREF, 1'b1);
        AREF_END = 1'b1;
        cyc("aref_release", O_NOP, 1'b1);
        AREF_END = 1'b0;
        cyc("prio_wr", O_WR, 1'b1);
        WR_REQ = 1'b0; WR_END = 1'b1;
        cyc("wr_release", O_NOP, 1'b1);
        WR_END = 1'b0;
        cyc("prio_rd", O_RD, 1'b1);

        // A refresh that arrives during READ waits, then beats a pending write.
        AREF_REQ = 1'b1; WR_REQ = 1'b1;
        cyc("rd_no_preempt", O_RD, 1'b1);
        RD_REQ = 1'b0; RD_END = 1'b1;
        cyc("rd_release", O_NOP, 1'b1);
        RD_END = 1'b0;
        cyc("aref_first", O_AREF, 1'b1);
        AREF_REQ = 1'b0; AREF_END = 1'b1;
        cyc("aref_release", O_NOP, 1'b1);
        AREF_END = 1'b0;
        cyc("wr_after_aref", O_WR, 1'b1);
        RD_REQ = 1'b1; WR_END = 1'b1;
        cyc("wr_release", O_NOP, 1'b1);
        WR_END = 1'b0;

        // WR_REQ and RD_REQ are both held continuously, and a refresh
        // request is injected mid-stream.
        for (int i = 0; i < 6; i++) begin
            if (aref_pend) begin
                own = O_AREF;
            end else begin
`ifdef SDRAM_ARB_RR_EN
                own = exp_last_wr ? O_RD : O_WR;
`else
                own = O_WR;
`endif
                exp_last_wr = (own == O_WR);
            end
            cyc("stream_grant", own, 1'b1);
            if (i == 1) begin
                AREF_REQ  = 1'b1;
                aref_pend = 1'b1;
            end
            cyc("stream_hold", own, 1'b1);
            case (own)
                O_AREF: begin AREF_END = 1'b1; AREF_REQ = 1'b0; aref_pend = 1'b0; end
                O_WR:   WR_END = 1'b1;
                default: RD_END = 1'b1;
            endcase
            cyc("stream_nop", O_NOP, 1'b1);
            AREF_END = 1'b0; WR_END = 1'b0; RD_END = 1'b0;
        end

        // Asserting reset during READ drops everything asynchronously.
        WR_REQ = 1'b0;
        cyc("rd_before_rst", O_RD, 1'b1);
        #2;
        Rst_n = 1'b0;
        now_chk("rst_mid_read", O_INIT, 1'b0, 1'b0);
        @(posedge Sys_clk); #1;
        RD_REQ = 1'b0;
        Rst_n  = 1'b1;
        cyc("init_again", O_INIT, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
